array_19_ctrl: RTL and testbench

Two-requester controller for the single-port 1024x60 array macro (`array_19_ext`) with 6-bit write lanes and one-cycle read latency. It arbitrates requester A and requester B round-robin onto the single RW port and routes each read response back to its issuer. It also runs a zero-fill sequence after reset, and again on demand, before accepting traffic. It sits directly between the two client pipelines and the macro instance.

---
 rtl/array_19_ctrl.sv | 124 ++++++++++++
 tb/tb_array_19_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/array_19_ctrl.sv
// Controller for the single-port array macro: zero-fill after reset or on demand,
// round-robin arbitration of two requesters, and read-response routing.
module array_19_ctrl #(
   parameter int DEPTH      = 1024,
   parameter int ADDR_W     = 10,
   parameter int LANES      = 10,
   parameter int LANE_W     = 6,
   parameter int INIT_CLEAR = 1
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    a_req_valid,
   output logic                    a_req_ready,
   input  logic                    a_req_write,
   input  logic [ADDR_W-1:0]       a_req_addr,
   input  logic [LANES-1:0]        a_req_wmask,
   input  logic [LANES*LANE_W-1:0] a_req_wdata,
   output logic                    a_resp_valid,
   output logic [LANES*LANE_W-1:0] a_resp_rdata,
   input  logic                    b_req_valid,
   output logic                    b_req_ready,
   input  logic                    b_req_write,
   input  logic [ADDR_W-1:0]       b_req_addr,
   input  logic [LANES-1:0]        b_req_wmask,
   input  logic [LANES*LANE_W-1:0] b_req_wdata,
   output logic                    b_resp_valid,
   output logic [LANES*LANE_W-1:0] b_resp_rdata,
   input  logic                    clear_start,
   output logic                    init_busy,
   output logic                    mem_en,
   output logic                    mem_wmode,
   output logic [ADDR_W-1:0]       mem_addr,
   output logic [LANES-1:0]        mem_wmask,
   output logic [LANES*LANE_W-1:0] mem_wdata,
   input  logic [LANES*LANE_W-1:0] mem_rdata
);

   typedef enum logic {CLEAR, RUN} state_t;

   state_t              state_reg, state_next;
   logic [ADDR_W-1:0]   clr_cnt_reg, clr_cnt_next;
   logic                prio_b_reg, prio_b_next;   // 1: B wins a tie
   logic                rd_pend_reg, rd_pend_next;
   logic                rd_own_reg, rd_own_next;   // 1: pending read belongs to B
   logic                grant_a, grant_b;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg   <= (INIT_CLEAR != 0) ? CLEAR : RUN;
         clr_cnt_reg <= '0;
         prio_b_reg  <= 1'b0;
         rd_pend_reg <= 1'b0;
         rd_own_reg  <= 1'b0;
      end else begin
         state_reg   <= state_next;
         clr_cnt_reg <= clr_cnt_next;
         prio_b_reg  <= prio_b_next;
         rd_pend_reg <= rd_pend_next;
         rd_own_reg  <= rd_own_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      clr_cnt_next = clr_cnt_reg;
      prio_b_next  = prio_b_reg;
      rd_pend_next = 1'b0;
      rd_own_next  = rd_own_reg;
      grant_a      = 1'b0;
      grant_b      = 1'b0;
      init_busy    = 1'b0;
      mem_en       = 1'b0;
      mem_wmode    = 1'b0;
      mem_addr     = '0;
      mem_wmask    = '0;
      mem_wdata    = '0;

      if (state_reg == CLEAR) begin
         init_busy = 1'b1;
         mem_en    = 1'b1;
         mem_wmode = 1'b1;
         mem_addr  = clr_cnt_reg;
         mem_wmask = '1;
         if (clr_cnt_reg == ADDR_W'(DEPTH - 1)) begin
            state_next   = RUN;
            clr_cnt_next = '0;
         end else begin
            clr_cnt_next = clr_cnt_reg + 1'b1;
         end
      end else if (clear_start) begin
         state_next = CLEAR;
      end else begin
         grant_a = a_req_valid && (!b_req_valid || !prio_b_reg);
         grant_b = b_req_valid && !grant_a;
         if (grant_a) begin
            mem_en       = 1'b1;
            mem_wmode    = a_req_write;
            mem_addr     = a_req_addr;
            mem_wmask    = a_req_wmask;
            mem_wdata    = a_req_wdata;
            prio_b_next  = 1'b1;
            rd_pend_next = !a_req_write;
            rd_own_next  = 1'b0;
         end else if (grant_b) begin
            mem_en       = 1'b1;
            mem_wmode    = b_req_write;
            mem_addr     = b_req_addr;
            mem_wmask    = b_req_wmask;
            mem_wdata    = b_req_wdata;
            prio_b_next  = 1'b0;
            rd_pend_next = !b_req_write;
            rd_own_next  = 1'b1;
         end
      end
   end

   assign a_req_ready  = grant_a;
   assign b_req_ready  = grant_b;
   assign a_resp_valid = rd_pend_reg && !rd_own_reg;
   assign b_resp_valid = rd_pend_reg && rd_own_reg;
   assign a_resp_rdata = a_resp_valid ? mem_rdata : '0;
   assign b_resp_rdata = b_resp_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_array_19_ctrl.sv
// Randomized bench for array_19_ctrl with a behavioural macro and a transaction-level
// reference model of clearing, arbitration and read return.
module tb_array_19_ctrl;

   localparam int DEPTH = 1024;
   localparam int DW    = 60;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          a_req_valid = 0, a_req_write = 0, b_req_valid = 0, b_req_write = 0;
   logic [9:0]    a_req_addr = 0, b_req_addr = 0, a_req_wmask = 0, b_req_wmask = 0;
   logic [DW-1:0] a_req_wdata = 0, b_req_wdata = 0;
   logic          a_req_ready, b_req_ready, a_resp_valid, b_resp_valid;
   logic [DW-1:0] a_resp_rdata, b_resp_rdata;
   logic          clear_start = 0;
   logic          init_busy, mem_en, mem_wmode;
   logic [9:0]    mem_addr, mem_wmask;
   logic [DW-1:0] mem_wdata, mem_rdata;

   always #5 clock = ~clock;

   array_19_ctrl dut (
      .clock(clock), .reset_n(reset_n),
      .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_write(a_req_write),
      .a_req_addr(a_req_addr), .a_req_wmask(a_req_wmask), .a_req_wdata(a_req_wdata),
      .a_resp_valid(a_resp_valid), .a_resp_rdata(a_resp_rdata),
      .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_write(b_req_write),
      .b_req_addr(b_req_addr), .b_req_wmask(b_req_wmask), .b_req_wdata(b_req_wdata),
      .b_resp_valid(b_resp_valid), .b_resp_rdata(b_resp_rdata),
      .clear_start(clear_start), .init_busy(init_busy),
      .mem_en(mem_en), .mem_wmode(mem_wmode), .mem_addr(mem_addr),
      .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // Behavioural macro: masked writes, registered read, no reset.
   logic [DW-1:0] mem_arr [0:DEPTH-1];
   always @(posedge clock) begin
      if (mem_en) begin
         if (mem_wmode) begin
            for (int i = 0; i < 10; i++)
               if (mem_wmask[i]) mem_arr[mem_addr][i*6 +: 6] <= mem_wdata[i*6 +: 6];
         end else begin
            mem_rdata <= mem_arr[mem_addr];
         end
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: observed %h expected %h", tag, $time, obs, exp);
      end
   endtask

   // Reference model state
   logic [DW-1:0] ref_mem [0:DEPTH-1];
   bit            m_busy, m_last_b, m_pend, m_own;
   int            m_idx;
   logic [DW-1:0] m_data;
   bit            ga, gb;
   bit            obs_busy, obs_a_valid;
   logic [DW-1:0] obs_a_rdata;

   task automatic model_reset();
      m_busy = 1; m_idx = 0; m_last_b = 1; m_pend = 0;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
   endtask

   task automatic step();
      bit            e_en, e_wm;
      logic [9:0]    e_addr, e_mask;
      logic [DW-1:0] e_wdata;
      @(negedge clock);
      ga = 0; gb = 0; e_en = 0; e_wm = 0; e_addr = 0; e_mask = 0; e_wdata = 0;
      if (m_busy) begin
         e_en = 1; e_wm = 1; e_addr = 10'(m_idx); e_mask = 10'h3FF;
      end else if (!clear_start) begin
         // Tie goes to whichever requester was not served last
         ga = a_req_valid && (!b_req_valid || m_last_b);
         gb = b_req_valid && !ga;
         if (ga) begin
            e_en = 1; e_wm = a_req_write; e_addr = a_req_addr; e_mask = a_req_wmask; e_wdata = a_req_wdata;
         end else if (gb) begin
            e_en = 1; e_wm = b_req_write; e_addr = b_req_addr; e_mask = b_req_wmask; e_wdata = b_req_wdata;
         end
      end
      check("a_ready",   64'(a_req_ready), 64'(ga));
      check("b_ready",   64'(b_req_ready), 64'(gb));
      check("init_busy", 64'(init_busy),   64'(m_busy));
      check("mem_en",    64'(mem_en),      64'(e_en));
      check("mem_wmode", 64'(mem_wmode),   64'(e_wm));
      check("mem_addr",  64'(mem_addr),    64'(e_addr));
      check("mem_wmask", 64'(mem_wmask),   64'(e_mask));
      check("mem_wdata", 64'(mem_wdata),   64'(e_wdata));
      check("a_resp_v",  64'(a_resp_valid), 64'(m_pend && !m_own));
      check("b_resp_v",  64'(b_resp_valid), 64'(m_pend && m_own));
      check("a_resp_d",  64'(a_resp_rdata), (m_pend && !m_own) ? 64'(m_data) : 64'd0);
      check("b_resp_d",  64'(b_resp_rdata), (m_pend && m_own) ? 64'(m_data) : 64'd0);
      obs_busy = init_busy; obs_a_valid = a_resp_valid; obs_a_rdata = a_resp_rdata;
      @(posedge clock);
      if (!reset_n) begin
         model_reset();
      end else begin
         m_pend = 0;
         if (m_busy) begin
            m_idx++;
            if (m_idx == DEPTH) begin m_busy = 0; m_idx = 0; end
         end else if (clear_start) begin
            m_busy = 1; m_idx = 0;
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
         end else if (ga || gb) begin
            if (e_wm) begin
               for (int i = 0; i < 10; i++)
                  if (e_mask[i]) ref_mem[e_addr][i*6 +: 6] = e_wdata[i*6 +: 6];
            end else begin
               m_pend = 1; m_own = gb; m_data = ref_mem[e_addr];
            end
            m_last_b = gb;
         end
      end
      #1;
   endtask

   task automatic rand_inputs();
      logic [63:0] r;
      a_req_valid = ($urandom % 4) != 0;
      b_req_valid = ($urandom % 4) != 0;
      a_req_write = $urandom % 2;
      b_req_write = $urandom % 2;
      a_req_addr  = 10'($urandom % 16);
      b_req_addr  = 10'($urandom % 16);
      a_req_wmask = 10'($urandom);
      b_req_wmask = 10'($urandom);
      r = {$urandom, $urandom}; a_req_wdata = r[59:0];
      r = {$urandom, $urandom}; b_req_wdata = r[59:0];
   endtask

   task automatic idle();
      a_req_valid = 0; b_req_valid = 0;
   endtask

   task automatic a_op(input bit wr, input logic [9:0] addr, input logic [9:0] mask, input logic [DW-1:0] data);
      b_req_valid = 0;
      a_req_valid = 1; a_req_write = wr; a_req_addr = addr; a_req_wmask = mask; a_req_wdata = data;
   endtask

   task automatic busy_len(input string tag);
      int n = 0;
      for (int k = 0; k < 1100; k++) begin
         rand_inputs();
         step();
         if (!obs_busy) break;
         n++;
      end
      check(tag, 64'(n), 64'(DEPTH));
   endtask

   initial begin
      model_reset();
      rand_inputs();
      step(); step();
      reset_n = 1;
      busy_len("init_clear_len");

      for (int i = 0; i < 3; i++) begin
         a_op(0, (i == 0) ? 10'd0 : (i == 1) ? 10'd511 : 10'd1023, 10'h0, '0);
         step();
      end
      idle(); step();

      // Contention: A reads 5, B reads 6
      a_req_valid = 1; a_req_write = 0; a_req_addr = 5;
      b_req_valid = 1; b_req_write = 0; b_req_addr = 6;
      repeat (4) step();
      idle(); step();

      a_op(1, 10'd7, 10'h3FF, {DW{1'b1}}); step();
      a_req_valid = 0;
      b_req_valid = 1; b_req_write = 1; b_req_addr = 7; b_req_wmask = 10'h001; b_req_wdata = '0; step();
      a_op(0, 10'd7, 10'h0, '0); step();
      idle(); step();
      check("mask_rdata", 64'(obs_a_rdata), 64'(60'hFFFFFFFFFFFFFC0));

      a_op(1, 10'd100, 10'h3FF, 60'h123456789ABCDEF); step();
      a_op(0, 10'd100, 10'h0, '0); step();
      idle(); step();
      check("raw_valid", 64'(obs_a_valid), 64'd1);
      check("raw_rdata", 64'(obs_a_rdata), 64'(60'h123456789ABCDEF));

      for (int i = 0; i < 1500; i++) begin rand_inputs(); step(); end

      a_op(0, 10'd3, 10'h0, '0);
      clear_start = 1; step();
      clear_start = 0;
      busy_len("clear_start_len");
      a_op(0, 10'd7, 10'h0, '0); step();
      a_op(0, 10'd100, 10'h0, '0); step();
      check("cleared_7", 64'(obs_a_rdata), 64'd0);
      idle(); step();
      check("cleared_100", 64'(obs_a_rdata), 64'd0);

      for (int i = 0; i < 500; i++) begin rand_inputs(); step(); end
      // Reset while a read response is due, then again part-way through the fill
      a_op(0, 10'd7, 10'h0, '0); step();
      reset_n = 0; model_reset(); step(); step();
      reset_n = 1;
      for (int i = 0; i < 300; i++) begin rand_inputs(); step(); end
      reset_n = 0; model_reset(); step(); step();
      reset_n = 1;
      busy_len("reset300_len");
      for (int i = 0; i < 200; i++) begin rand_inputs(); step(); end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
